blit_drawline: RTL and testbench
================================

BLIT_DRAWLINE -- requirements
Module: blit_drawline

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named as listed below.
REQ-002 clock  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  downstream back-pressure; while high, the current pixel is not consumed.
REQ-005 x1, y1  input  16 signed  line start point.
REQ-006 x2, y2  input  16 signed  line end point.
REQ-007 start  input  1  level request; sampled only in IDLE.
REQ-008 x, y  output  16  current pixel coordinate, two's complement.
REQ-009 write  output  1  current x/y is a valid pixel.
REQ-010 done  output  1  line complete; held until start falls.

Function
REQ-011 The block SHALL implement a three-state FSM: IDLE, DRAW, DONE.
REQ-012 IDLE: write=0 and done=0.
REQ-013 IDLE with start=1 at a clock edge SHALL latch x1/y1 as current x/y and latch x2/y2 as the target, then enter DRAW.
REQ-014 On that IDLE edge the block SHALL compute dx=|x2-x1| and dy=-|y2-y1|.
REQ-015 On that IDLE edge the block SHALL set sx=+1 if x1<x2, else -1, and sy=+1 if y1<y2, else -1.
REQ-016 On that IDLE edge the block SHALL set err=dx+dy.
REQ-017 dx, dy, err and e2 SHALL use at least 19-bit signed arithmetic so no overflow occurs over the full 16-bit signed input range.
REQ-018 DRAW: write=1 combinationally, and x/y SHALL show the current pixel.
REQ-019 A pixel SHALL be consumed on an edge where write=1 and stall=0.
REQ-020 The first pixel SHALL be (x1,y1) on the first cycle after the start edge.
REQ-021 On a consuming edge, if the current pixel equals (x2,y2), the FSM SHALL enter DONE.
REQ-022 Otherwise, on a consuming edge, the block SHALL set e2=2*err.
REQ-023 If e2>=dy: x+=sx and err+=dy.
REQ-024 If e2<=dx: y+=sy and err+=dx.
REQ-025 Both comparisons SHALL use the pre-update err, and both updates SHALL apply in the same cycle (diagonal step).
REQ-026 While stall=1 in DRAW, x, y, err and state SHALL hold and write SHALL stay 1.
REQ-027 The number of pixels SHALL be max(dx,|dy|)+1, each emitted exactly once.
REQ-028 Every pixel SHALL be 8-connected to the previous one.
REQ-029 The last pixel SHALL be exactly (x2,y2).
REQ-030 Degenerate line (x1,y1)=(x2,y2): exactly one pixel, then DONE.
REQ-031 DONE: done=1 and write=0.
REQ-032 DONE SHALL remain until an edge with start=0, then go to IDLE.
REQ-033 Start held high through DONE SHALL NOT restart a line.
REQ-034 stall SHALL have no effect in IDLE or DONE.
REQ-035 Input endpoint changes after the start edge SHALL NOT affect the line in progress.
REQ-036 Throughput: one pixel per unstalled cycle.

Reset
REQ-037 reset=1 at an edge SHALL force IDLE from any state, including mid-line, and abandon any line in progress.
REQ-038 After reset: x=0, y=0, write=0, done=0, err=0.
REQ-039 After reset the block SHALL accept a new start on the first edge after reset deasserts.

Verification
REQ-040 (10,20)->(30,48), start held, stall=0 -> 29 write cycles; first (10,20), last (30,48); done=1 next cycle; IDLE after start drops.
REQ-041 (0,0)->(5,0) -> six pixels (0..5,0), y constant.
REQ-042 (7,-3)->(7,-3) -> exactly one pixel (7,-3), then done.
REQ-043 (5,5)->(0,2) -> six pixels, x decreasing each step, y decreasing 3 times; ends at (0,2).
REQ-044 (0,0)->(4,4) with stall=1 for 3 cycles at the second pixel -> (1,1) held with write=1 during stall; sequence (0,0)..(4,4) without duplicates or loss.
REQ-045 reset asserted at the third pixel of a long line -> write=0, x=y=0 next cycle; a new start then draws correctly from its own x1,y1.

Source files
------------

// File: rtl/blit_drawline.sv
// Bresenham line rasteriser: walks from (x1,y1) to (x2,y2) emitting one
// 8-connected pixel per unstalled cycle, with IDLE/DRAW/DONE sequencing.
module blit_drawline (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic signed [15:0] x1,
  input  logic signed [15:0] y1,
  input  logic signed [15:0] x2,
  input  logic signed [15:0] y2,
  input  logic               start,
  output logic [15:0]        x,
  output logic [15:0]        y,
  output logic               write,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [15:0]        x_r;
  logic [15:0]        y_r;
  logic [15:0]        tx_r;
  logic [15:0]        ty_r;
  logic signed [19:0] dx_r;
  logic signed [19:0] dy_r;
  logic signed [19:0] err_r;
  logic               sx_neg_r;
  logic               sy_neg_r;

  logic signed [19:0] ddx_s;
  logic signed [19:0] ddy_s;
  logic signed [19:0] adx_s;
  logic signed [19:0] ady_s;
  logic               sx_neg_s;
  logic               sy_neg_s;
  logic signed [19:0] e2_s;
  logic               step_x_s;
  logic               step_y_s;
  logic signed [19:0] err_step_s;
  logic [15:0]        x_step_s;
  logic [15:0]        y_step_s;
  logic               at_end_s;
  logic               write_s;
  logic               done_s;

  // Line setup: 20-bit signed deltas cannot overflow for any 16-bit endpoints.
  always_comb begin
    ddx_s    = $signed({{4{x2[15]}}, x2}) - $signed({{4{x1[15]}}, x1});
    ddy_s    = $signed({{4{y2[15]}}, y2}) - $signed({{4{y1[15]}}, y1});
    sx_neg_s = (x1 >= x2);
    sy_neg_s = (y1 >= y2);
    if (ddx_s[19]) begin
      adx_s = -ddx_s;
    end else begin
      adx_s = ddx_s;
    end
    if (ddy_s[19]) begin
      ady_s = -ddy_s;
    end else begin
      ady_s = ddy_s;
    end
  end

  // One Bresenham step; both tests use the pre-update error term.
  always_comb begin
    e2_s       = err_r + err_r;
    step_x_s   = (e2_s >= dy_r);
    step_y_s   = (e2_s <= dx_r);
    err_step_s = err_r + (step_x_s ? dy_r : 20'sd0) + (step_y_s ? dx_r : 20'sd0);
    if (step_x_s) begin
      x_step_s = x_r + (sx_neg_r ? 16'hFFFF : 16'h0001);
    end else begin
      x_step_s = x_r;
    end
    if (step_y_s) begin
      y_step_s = y_r + (sy_neg_r ? 16'hFFFF : 16'h0001);
    end else begin
      y_step_s = y_r;
    end
    at_end_s = (x_r == tx_r) && (y_r == ty_r);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = DRAW;
        end else begin
          state_next_s = IDLE;
        end
      end
      DRAW: begin
        if (!stall && at_end_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAW;
        end
      end
      DONE: begin
        if (!start) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    write_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE:    begin write_s = 1'b0; done_s = 1'b0; end
      DRAW:    begin write_s = 1'b1; done_s = 1'b0; end
      DONE:    begin write_s = 1'b0; done_s = 1'b1; end
      default: begin write_s = 1'b0; done_s = 1'b0; end
    endcase
  end

  // Datapath: endpoint/setup latch on start, pixel advance on each consumed non-final pixel
  always_ff @(posedge clock) begin
    if (reset) begin
      x_r      <= 16'd0;
      y_r      <= 16'd0;
      tx_r     <= 16'd0;
      ty_r     <= 16'd0;
      dx_r     <= 20'sd0;
      dy_r     <= 20'sd0;
      err_r    <= 20'sd0;
      sx_neg_r <= 1'b0;
      sy_neg_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            x_r      <= x1;
            y_r      <= y1;
            tx_r     <= x2;
            ty_r     <= y2;
            dx_r     <= adx_s;
            dy_r     <= -ady_s;
            err_r    <= adx_s - ady_s;
            sx_neg_r <= sx_neg_s;
            sy_neg_r <= sy_neg_s;
          end
        end
        DRAW: begin
          if (!stall && !at_end_s) begin
            x_r   <= x_step_s;
            y_r   <= y_step_s;
            err_r <= err_step_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign x     = x_r;
  assign y     = y_r;
  assign write = write_s;
  assign done  = done_s;

endmodule

// File: tb/tb_blit_drawline.sv
// Self-checking bench for blit_drawline: randomized lines and stalls compared
// against a plain-integer Bresenham reference, plus directed boundary cases.
module tb_blit_drawline;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               stall = 1'b0;
  logic signed [15:0] x1 = 16'sd0;
  logic signed [15:0] y1 = 16'sd0;
  logic signed [15:0] x2 = 16'sd0;
  logic signed [15:0] y2 = 16'sd0;
  logic               start = 1'b0;
  logic [15:0]        x;
  logic [15:0]        y;
  logic               write;
  logic               done;

  int asserts  = 0;
  int failures = 0;

  int mx[$];
  int my[$];
  int last_count;
  int first_x, first_y, last_x, last_y;

  blit_drawline dut (
    .clock (clock),
    .reset (reset),
    .stall (stall),
    .x1    (x1),
    .y1    (y1),
    .x2    (x2),
    .y2    (y2),
    .start (start),
    .x     (x),
    .y     (y),
    .write (write),
    .done  (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: textbook Bresenham on 32-bit ints, up to 'limit' pixels.
  task automatic build_model(input int ax1, input int ay1, input int ax2, input int ay2, input int limit);
    int cx, cy, dx, dy, sx, sy, err, e2;
    mx.delete();
    my.delete();
    cx = ax1; cy = ay1;
    dx = (ax2 > ax1) ? ax2 - ax1 : ax1 - ax2;
    dy = (ay2 > ay1) ? ay1 - ay2 : ay2 - ay1;
    sx = (ax1 < ax2) ? 1 : -1;
    sy = (ay1 < ay2) ? 1 : -1;
    err = dx + dy;
    while (mx.size() < limit) begin
      mx.push_back(cx);
      my.push_back(cy);
      if (cx == ax2 && cy == ay2) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; cx += sx; end
      if (e2 <= dx) begin err += dx; cy += sy; end
    end
  endtask

  // Draw one line; mode 0 = no stall, 1 = random stall, 2 = 3-cycle stall at pixel stall_at.
  task automatic run_line(input int ax1, input int ay1, input int ax2, input int ay2,
                          input int mode, input int stall_at, input string name);
    int obs_n, cyc, budget, stall_cnt;
    bit s, bad;
    build_model(ax1, ay1, ax2, ay2, 1000000);
    x1 = 16'(ax1); y1 = 16'(ay1); x2 = 16'(ax2); y2 = 16'(ay2);
    start = 1'b1;
    stall = 1'($urandom_range(0, 1));
    tick();
    obs_n = 0; cyc = 0; stall_cnt = 0; bad = 1'b0;
    last_count = 0;
    budget = 4 * mx.size() + 20;
    while (done !== 1'b1 && cyc < budget) begin
      x1 = 16'($urandom); y1 = 16'($urandom); x2 = 16'($urandom); y2 = 16'($urandom);
      asserts++;
      if (write !== 1'b1 || obs_n >= mx.size() ||
          x !== 16'(mx[obs_n]) || y !== 16'(my[obs_n])) begin
        failures++;
        $display("FAIL %s pixel %0d: got x=%0d y=%0d write=%b, expected x=%0d y=%0d write=1",
                 name, obs_n, $signed(x), $signed(y), write,
                 (obs_n < mx.size()) ? mx[obs_n] : 0, (obs_n < my.size()) ? my[obs_n] : 0);
        bad = 1'b1;
        break;
      end
      s = 1'b0;
      if (mode == 1) s = ($urandom_range(0, 2) == 0);
      else if (mode == 2 && obs_n == stall_at && stall_cnt < 3) begin
        s = 1'b1;
        stall_cnt++;
      end
      stall = s;
      if (!s) begin
        if (obs_n == 0) begin first_x = $signed(x); first_y = $signed(y); end
        last_x = $signed(x); last_y = $signed(y);
      end
      tick();
      if (!s) obs_n++;
      cyc++;
    end
    last_count = obs_n;
    asserts++;
    if (done !== 1'b1 || write !== 1'b0 || obs_n != mx.size()) begin
      failures++;
      $display("FAIL %s end: got done=%b write=%b pixels=%0d, expected done=1 write=0 pixels=%0d",
               name, done, write, obs_n, mx.size());
      bad = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      stall = 1'($urandom_range(0, 1));
      tick();
      asserts++;
      if (done !== 1'b1 || write !== 1'b0) begin
        failures++;
        $display("FAIL %s done_hold: got done=%b write=%b, expected done=1 write=0", name, done, write);
      end
    end
    start = 1'b0;
    stall = 1'b0;
    tick();
    asserts++;
    if (done !== 1'b0 || write !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_return: got done=%b write=%b, expected 0 0", name, done, write);
    end
    if (bad) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end
  endtask

  // Check the first k pixels, then assert reset while pixel k is showing.
  task automatic check_prefix(input int ax1, input int ay1, input int ax2, input int ay2,
                              input int k, input string name);
    build_model(ax1, ay1, ax2, ay2, k + 1);
    x1 = 16'(ax1); y1 = 16'(ay1); x2 = 16'(ax2); y2 = 16'(ay2);
    start = 1'b1;
    stall = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i <= k; i++) begin
      asserts++;
      if (write !== 1'b1 || x !== 16'(mx[i]) || y !== 16'(my[i])) begin
        failures++;
        $display("FAIL %s pixel %0d: got x=%0d y=%0d write=%b, expected x=%0d y=%0d write=1",
                 name, i, $signed(x), $signed(y), write, mx[i], my[i]);
      end
      if (i < k) tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    asserts++;
    if (write !== 1'b0 || done !== 1'b0 || x !== 16'd0 || y !== 16'd0) begin
      failures++;
      $display("FAIL %s after_reset: got x=%0d y=%0d write=%b done=%b, expected 0 0 0 0",
               name, $signed(x), $signed(y), write, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    tick();
    tick();
    asserts++;
    if (x !== 16'd0 || y !== 16'd0 || write !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got x=%0d y=%0d write=%b done=%b, expected 0 0 0 0",
               x, y, write, done);
    end
    reset = 1'b0;
    start = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    asserts++;
    if (write !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle_stall: got write=%b done=%b, expected 0 0", write, done);
    end
    stall = 1'b0;
  endtask

  task automatic check_summary(input string name, input int n, input int fx, input int fy,
                               input int lx, input int ly);
    asserts++;
    if (last_count != n || first_x != fx || first_y != fy || last_x != lx || last_y != ly) begin
      failures++;
      $display("FAIL %s shape: got n=%0d first=(%0d,%0d) last=(%0d,%0d), expected n=%0d first=(%0d,%0d) last=(%0d,%0d)",
               name, last_count, first_x, first_y, last_x, last_y, n, fx, fy, lx, ly);
    end
  endtask

  task automatic test_directed();
    run_line(10, 20, 30, 48, 0, 0, "long_diag");
    check_summary("long_diag", 29, 10, 20, 30, 48);
    run_line(0, 0, 5, 0, 0, 0, "horizontal");
    check_summary("horizontal", 6, 0, 0, 5, 0);
    run_line(7, -3, 7, -3, 0, 0, "degenerate");
    check_summary("degenerate", 1, 7, -3, 7, -3);
    run_line(5, 5, 0, 2, 0, 0, "negative_dir");
    check_summary("negative_dir", 6, 5, 5, 0, 2);
  endtask

  task automatic test_stall();
    run_line(0, 0, 4, 4, 2, 1, "stall_diag");
    check_summary("stall_diag", 5, 0, 0, 4, 4);
  endtask

  task automatic test_random();
    int ax1, ay1, ax2, ay2;
    for (int i = 0; i < 30; i++) begin
      ax1 = int'($urandom_range(0, 400)) - 200;
      ay1 = int'($urandom_range(0, 400)) - 200;
      ax2 = int'($urandom_range(0, 400)) - 200;
      ay2 = int'($urandom_range(0, 400)) - 200;
      if (i % 10 == 3) begin ax2 = ax1; ay2 = ay1; end
      if (i % 10 == 5) ay2 = ay1;
      if (i % 10 == 7) ax2 = ax1;
      run_line(ax1, ay1, ax2, ay2, 1, 0, "random");
    end
  endtask

  task automatic test_midline_reset();
    check_prefix(100, -50, -900, 400, 2, "midline_reset");
    run_line(-3, 8, 6, -1, 0, 0, "after_reset");
    check_summary("after_reset", 10, -3, 8, 6, -1);
  endtask

  task automatic test_wide();
    check_prefix(-32768, 100, 32767, -32768, 40, "wide_a");
    check_prefix(32767, 32767, -32768, -32000, 40, "wide_b");
    run_line(32767, -32768, 32760, -32755, 1, 0, "edge_short");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_midline_reset();
    test_wide();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
